mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Pipeline-side initiator for the data memory port: issues `MEM_SB/`MEM_SH/`MEM_SW commands, addresses and store data, and reads the combinational word read-back.
- Sits in the MEM stage, between the pipeline's load/store request and the data memory.
- Performs lane extraction and sign/zero extension for loads.
- Splits misaligned and word-crossing accesses into aligned word reads and read-modify-write word stores, stalling the pipeline until they finish.

Parameters:
SPLIT_EN, 1, 1 = misaligned accesses are serviced by splitting; 0 = misaligned requests complete with resp_err and make no memory access

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present; accepted when req_valid & req_ready
req_ready  output  1  high exactly when FSM is IDLE
req_load  input  1  1 = load, 0 = store
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address, little-endian
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  one-cycle pulse on completion (loads and stores)
resp_rdata  output  32  extended load data, valid with resp_valid, else 0
resp_err  output  1  pulses with resp_valid for an illegal size, or for a misaligned request when SPLIT_EN=0
MEM_mem_cmd  output  4  `MEM_SB/`MEM_SH/`MEM_SW from sys_defs.vh; 4'h0 = no-op/read
MEM_mem_addr  output  32  memory address
MEM_mem_din  output  32  store data, right-aligned for SB/SH
DM_mem_dout  input  32  combinational read of word {MEM_mem_addr[31:2],2'b00}

Behaviour:
- Interface and reset:
  - Single clock clk.
  - rst is asynchronous and active-high. It forces IDLE and clears all outputs: cmd 4'h0, addr 0, din 0, resp_* 0, req_ready 1.
  - All memory-side outputs are registered from FSM state and latched request fields.
- Request handling:
  - A request is accepted in cycle N.
  - Fields are latched; req_* is ignored while not ready.
  - resp_valid is asserted in a cycle where the FSM is already IDLE, so back-to-back acceptance in the resp cycle is legal.
- Classification:
  - Aligned: byte; half with addr[0]=0; word with addr[1:0]=0.
  - In-word misaligned: half at offset 1.
  - Crossing: half at offset 3; word at offset 1, 2 or 3.
- FSM states: IDLE, ACC (aligned), RD0, RD1, WR0, WR1, ERR.
- Aligned access:
  - IDLE→ACC in N+1.
  - Store: drive SB/SH/SW with addr=req_addr and din=req_wdata.
  - Load: drive cmd 0, addr=req_addr, and capture DM_mem_dout.
  - resp_valid in N+2.
  - Load lane = word[8*off+7 : 8*off] (byte) or word[8*off+15 : 8*off] (half), where off = addr[1:0].
- Misaligned load:
  - RD0 reads word A = addr & ~3 (N+1).
  - Crossing only: RD1 reads word A+4 (N+2).
  - Bytes are assembled little-endian across the two words and then extended.
  - resp_valid in N+2 (in-word) or N+3 (crossing).
- Misaligned store (read-modify-write, SW only):
  - RD0 reads A; RD1 reads A+4 if crossing.
  - WR0 issues SW to A with the merged bytes.
  - WR1 issues SW to A+4 if crossing.
  - Unaffected bytes keep their read values.
  - resp_valid in N+3 (in-word) or N+5 (crossing).
- Error path: size 11, or misalignment with SPLIT_EN=0, goes IDLE→ERR. No memory access is made; resp_valid=resp_err=1 and rdata=0 in N+2.
- Store responses: resp_rdata=0.
- Addresses: A+4 wraps modulo 2^32.
- Reset mid-operation: any store already issued stays in memory; no further commands are issued; outputs clear asynchronously.

Test Plan:
- Aligned SW: SW 0x11223344 @0x100 → cmd=`MEM_SW, addr 0x100 in N+1; resp_valid in N+2, rdata 0. Then LBU @0x102 → rdata 0x00000022 at N+2.
- Sign extension and crossing load: SW 0x8899AABB @0x104, then LH signed @0x103 → reads 0x100 (N+1) and 0x104 (N+2); rdata 0xFFFFBB11 at N+3. LHU @0x103 → 0x0000BB11.
- Crossing store: with the above contents, SW 0xDEADBEEF @0x101 → cmd 0,0,SW,SW over N+1..N+4; resp N+5. Afterwards LW 0x100 = 0xADBEEF44 and LW 0x104 = 0x8899AADE.
- In-word half store: SH 0xCAFE @0x101 on 0x11223344 → RD0, then WR0 SW 0x11CAFE44; resp N+3. With SPLIT_EN=0 the same request → resp_err at N+2 and no store command.
- Illegal size and back-to-back: size 11 → resp_valid & resp_err at N+2, cmd stays 0. A new req_valid in the resp cycle is accepted (req_ready=1).
- Reset mid-op: assert rst the cycle after WR0 of the crossing store → all outputs 0 immediately. 0x100 is updated, 0x104 is unchanged; req_ready=1 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage initiator for the data memory port. It accepts one load/store
//   request at a time. Aligned accesses go straight to memory. Misaligned and
//   word-crossing accesses are split into aligned word reads plus
//   read-modify-write word stores. Loads return lane-extracted and extended data.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   req_*             : pipeline request (accepted when req_valid & req_ready)
//   req_ready         : high exactly while the FSM is IDLE
//   resp_valid/err    : one-cycle completion pulse; err for illegal size or
//                       for a misaligned request when SPLIT_EN=0
//   resp_rdata        : extended load data with resp_valid, otherwise 0
//   MEM_mem_cmd/addr/din : registered memory command, address and store data
//   DM_mem_dout       : combinational read of word {MEM_mem_addr[31:2],2'b00}

`ifndef MEM_SB
`define MEM_SB 4'h1
`endif
`ifndef MEM_SH
`define MEM_SH 4'h2
`endif
`ifndef MEM_SW
`define MEM_SW 4'h3
`endif

module mem_access_unit #(
    parameter logic SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [3:0]  MEM_mem_cmd,
    output logic [31:0] MEM_mem_addr,
    output logic [31:0] MEM_mem_din,
    input  logic [31:0] DM_mem_dout
);

    typedef enum logic [2:0] {IDLE, ACC, RD0, RD1, WR0, WR1, ERR} state_t;

    state_t      state_q;
    logic        load_q, uns_q, cross_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] wdata_q;
    logic [63:0] buf_q;
    logic [3:0]  cmd_q;
    logic [31:0] maddr_q, din_q, rdata_q;
    logic        resp_valid_q, resp_err_q;

    logic        misal_d, cross_d, illegal_d;
    logic [3:0]  store_cmd_d;
    logic [63:0] cur64_d, merged_d;
    logic [31:0] load_d;

    // Pull the addressed lane out of a little-endian two-word window.
    function automatic logic [31:0] lane(input logic [63:0] win, input logic [1:0] off);
        return 32'(win >> {off, 3'b000});
    endfunction

    // Sign- or zero-extend a right-aligned byte/half; words pass through.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = uns ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            2'b01:   r = uns ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Overlay the store bytes onto the read-back window; other bytes keep their value.
    function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [63:0] mask;
        case (size)
            2'b00:   mask = 64'h0000_0000_0000_00FF;
            2'b01:   mask = 64'h0000_0000_0000_FFFF;
            default: mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        return (old & ~(mask << {off, 3'b000})) |
               (({32'h0000_0000, wdata} & mask) << {off, 3'b000});
    endfunction

    // Classify the incoming request by size and byte offset.
    always_comb begin
        misal_d     = 1'b0;
        cross_d     = 1'b0;
        illegal_d   = 1'b0;
        store_cmd_d = `MEM_SW;
        case (req_size)
            2'b00: store_cmd_d = `MEM_SB;
            2'b01: begin
                store_cmd_d = `MEM_SH;
                misal_d     = req_addr[0];
                cross_d     = (req_addr[1:0] == 2'b11);
            end
            2'b10: begin
                misal_d = |req_addr[1:0];
                cross_d = |req_addr[1:0];
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Read-back window: in RD1 the high word arrives live and the low word is buffered.
    always_comb begin
        if (state_q == RD1) begin
            cur64_d = {DM_mem_dout, buf_q[31:0]};
        end else begin
            cur64_d = {32'h0000_0000, DM_mem_dout};
        end
        merged_d = merge_bytes(cur64_d, wdata_q, size_q, off_q);
        load_d   = extend(lane(cur64_d, off_q), size_q, uns_q);
    end

    // Access FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            load_q       <= 1'b0;
            uns_q        <= 1'b0;
            cross_q      <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0000_0000;
            buf_q        <= 64'h0;
            cmd_q        <= 4'h0;
            maddr_q      <= 32'h0000_0000;
            din_q        <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            case (state_q)
                IDLE: begin
                    cmd_q   <= 4'h0;
                    maddr_q <= 32'h0000_0000;
                    din_q   <= 32'h0000_0000;
                    if (req_valid) begin
                        load_q  <= req_load;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        cross_q <= cross_d;
                        wdata_q <= req_wdata;
                        if (illegal_d || (misal_d && !SPLIT_EN)) begin
                            state_q <= ERR;
                        end else if (!misal_d) begin
                            state_q <= ACC;
                            cmd_q   <= req_load ? 4'h0 : store_cmd_d;
                            maddr_q <= req_addr;
                            din_q   <= req_load ? 32'h0000_0000 : req_wdata;
                        end else begin
                            state_q <= RD0;
                            maddr_q <= {req_addr[31:2], 2'b00};
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACC: begin
                    state_q      <= IDLE;
                    cmd_q        <= 4'h0;
                    maddr_q      <= 32'h0000_0000;
                    din_q        <= 32'h0000_0000;
                    resp_valid_q <= 1'b1;
                    rdata_q      <= load_q ? load_d : 32'h0000_0000;
                end
                RD0: begin
                    if (cross_q) begin
                        state_q     <= RD1;
                        buf_q[31:0] <= DM_mem_dout;
                        maddr_q     <= maddr_q + 32'd4;
                    end else if (load_q) begin
                        state_q      <= IDLE;
                        maddr_q      <= 32'h0000_0000;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= load_d;
                    end else begin
                        state_q <= WR0;
                        buf_q   <= merged_d;
                        cmd_q   <= `MEM_SW;
                        din_q   <= merged_d[31:0];
                    end
                end
                RD1: begin
                    if (load_q) begin
                        state_q      <= IDLE;
                        maddr_q      <= 32'h0000_0000;
                        resp_valid_q <= 1'b1;
                        rdata_q      <= load_d;
                    end else begin
                        // Write back the low word first, then the (wrapped) high word.
                        state_q <= WR0;
                        buf_q   <= merged_d;
                        cmd_q   <= `MEM_SW;
                        maddr_q <= maddr_q - 32'd4;
                        din_q   <= merged_d[31:0];
                    end
                end
                WR0: begin
                    if (cross_q) begin
                        state_q <= WR1;
                        cmd_q   <= `MEM_SW;
                        maddr_q <= maddr_q + 32'd4;
                        din_q   <= buf_q[63:32];
                    end else begin
                        state_q      <= IDLE;
                        cmd_q        <= 4'h0;
                        maddr_q      <= 32'h0000_0000;
                        din_q        <= 32'h0000_0000;
                        resp_valid_q <= 1'b1;
                    end
                end
                WR1: begin
                    state_q      <= IDLE;
                    cmd_q        <= 4'h0;
                    maddr_q      <= 32'h0000_0000;
                    din_q        <= 32'h0000_0000;
                    resp_valid_q <= 1'b1;
                end
                ERR: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    cmd_q   <= 4'h0;
                end
            endcase
        end
    end

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = rdata_q;
    assign MEM_mem_cmd  = cmd_q;
    assign MEM_mem_addr = maddr_q;
    assign MEM_mem_din  = din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam logic [3:0] C_SB = 4'h1;
    localparam logic [3:0] C_SH = 4'h2;
    localparam logic [3:0] C_SW = 4'h3;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv_drv, sel;
    logic        req_load, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        rdy0, rsp0, err0, rdy1, rsp1, err1;
    logic [31:0] rdata0, addr0, din0, dout0, rdata1, addr1, din1, dout1;
    logic [3:0]  cmd0, cmd1;
    logic [31:0] mem0 [0:255];
    logic [31:0] mem1 [0:255];

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.SPLIT_EN(1'b1)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv_drv & ~sel), .req_ready(rdy0),
        .req_load(req_load), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsp0),
        .resp_rdata(rdata0), .resp_err(err0), .MEM_mem_cmd(cmd0),
        .MEM_mem_addr(addr0), .MEM_mem_din(din0), .DM_mem_dout(dout0));

    mem_access_unit #(.SPLIT_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv_drv & sel), .req_ready(rdy1),
        .req_load(req_load), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(rsp1),
        .resp_rdata(rdata1), .resp_err(err1), .MEM_mem_cmd(cmd1),
        .MEM_mem_addr(addr1), .MEM_mem_din(din1), .DM_mem_dout(dout1));

    // Word-addressed data memories (1 KiB window), combinational read.
    assign dout0 = mem0[addr0[9:2]];
    assign dout1 = mem1[addr1[9:2]];

    function automatic logic [31:0] wr_word(input logic [31:0] old, input logic [3:0] cmd,
                                            input logic [1:0] off, input logic [31:0] din);
        logic [31:0] w;
        w = old;
        case (cmd)
            C_SB:    w[8*off +: 8] = din[7:0];
            C_SH:    w[16*off[1] +: 16] = din[15:0];
            C_SW:    w = din;
            default: w = old;
        endcase
        return w;
    endfunction

    always @(posedge clk) begin
        mem0[addr0[9:2]] <= wr_word(mem0[addr0[9:2]], cmd0, addr0[1:0], din0);
        mem1[addr1[9:2]] <= wr_word(mem1[addr1[9:2]], cmd1, addr1[1:0], din1);
    end

    // Observation of the currently selected unit.
    logic        o_rdy, o_rsp, o_err;
    logic [3:0]  o_cmd;
    logic [31:0] o_addr, o_din, o_rdata;
    assign o_rdy   = sel ? rdy1   : rdy0;
    assign o_rsp   = sel ? rsp1   : rsp0;
    assign o_err   = sel ? err1   : err0;
    assign o_cmd   = sel ? cmd1   : cmd0;
    assign o_addr  = sel ? addr1  : addr0;
    assign o_din   = sel ? din1   : din0;
    assign o_rdata = sel ? rdata1 : rdata0;

    logic [3:0]  h_cmd  [1:8];
    logic [31:0] h_addr [1:8];
    logic [31:0] h_din  [1:8];
    logic [31:0] h_rdata;
    logic        h_err;
    logic [3:0]  any_cmd;
    int          lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current (negedge) time and record each cycle until response.
    task automatic txn(input logic u, input logic ld, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd);
        sel = u;
        chk("req_ready", {31'h0, o_rdy}, 32'h1);
        req_load = ld; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        rv_drv = 1'b1;
        @(posedge clk);
        #1 rv_drv = 1'b0;
        lat = 0; any_cmd = 4'h0; h_rdata = 32'h0; h_err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            h_cmd[k] = 4'h0; h_addr[k] = 32'h0; h_din[k] = 32'h0;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            h_cmd[k] = o_cmd; h_addr[k] = o_addr; h_din[k] = o_din;
            any_cmd = any_cmd | o_cmd;
            if (o_rsp) begin
                lat = k; h_rdata = o_rdata; h_err = o_err;
                break;
            end
        end
    endtask

    task automatic chk_resp(input string tag, input int exp_lat, input logic [31:0] exp_rd,
                            input logic exp_err);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, h_rdata, exp_rd);
        chk({tag, "_err"}, {31'h0, h_err}, {31'h0, exp_err});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 32'h0; mem1[i] = 32'h0;
        end
        rst = 1'b1; rv_drv = 1'b0; sel = 1'b0;
        req_load = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk);
        chk("rst_cmd", {28'h0, cmd0}, 32'h0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_din", din0, 32'h0);
        chk("rst_resp", {30'h0, rsp0, err0}, 32'h0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_ready", {31'h0, rdy0}, 32'h1);
        rst = 1'b0;

        // Aligned SW then LBU
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h11223344);
        chk("sw_cmd1", {28'h0, h_cmd[1]}, {28'h0, C_SW});
        chk("sw_addr1", h_addr[1], 32'h100);
        chk("sw_din1", h_din[1], 32'h11223344);
        chk_resp("sw", 2, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 2'b00, 1'b1, 32'h102, 32'h0);
        chk("lbu_cmd1", {28'h0, h_cmd[1]}, 32'h0);
        chk_resp("lbu", 2, 32'h00000022, 1'b0);

        // Crossing loads, signed and unsigned
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h8899AABB);
        chk_resp("sw2", 2, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h0);
        chk("lh_addr1", h_addr[1], 32'h100);
        chk("lh_addr2", h_addr[2], 32'h104);
        chk("lh_cmds", {28'h0, any_cmd}, 32'h0);
        chk_resp("lh", 3, 32'hFFFFBB11, 1'b0);
        txn(1'b0, 1'b1, 2'b01, 1'b1, 32'h103, 32'h0);
        chk_resp("lhu", 3, 32'h0000BB11, 1'b0);

        // Crossing word store (read-modify-write of two words)
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h101, 32'hDEADBEEF);
        chk("xsw_cmds", {h_cmd[1], h_cmd[2], h_cmd[3], h_cmd[4], 16'h0},
            {4'h0, 4'h0, C_SW, C_SW, 16'h0});
        chk("xsw_addr3", h_addr[3], 32'h100);
        chk("xsw_din3", h_din[3], 32'hADBEEF44);
        chk("xsw_addr4", h_addr[4], 32'h104);
        chk("xsw_din4", h_din[4], 32'h8899AADE);
        chk_resp("xsw", 5, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        chk_resp("lw100", 2, 32'hADBEEF44, 1'b0);
        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h0);
        chk_resp("lw104", 2, 32'h8899AADE, 1'b0);

        // In-word misaligned half store
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h11223344);
        txn(1'b0, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0000CAFE);
        chk("sh_cmd1", {28'h0, h_cmd[1]}, 32'h0);
        chk("sh_cmd2", {28'h0, h_cmd[2]}, {28'h0, C_SW});
        chk("sh_din2", h_din[2], 32'h11CAFE44);
        chk_resp("sh", 3, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        chk_resp("lw_sh", 2, 32'h11CAFE44, 1'b0);

        // Same half store with splitting disabled
        txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h11223344);
        txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h0000CAFE);
        chk("nosplit_cmds", {28'h0, any_cmd}, 32'h0);
        chk_resp("nosplit", 2, 32'h0, 1'b1);
        txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        chk_resp("nosplit_lw", 2, 32'h11223344, 1'b0);

        // Illegal size, then back-to-back signed byte load in the response cycle
        txn(1'b0, 1'b1, 2'b11, 1'b0, 32'h100, 32'h0);
        chk("ill_cmds", {28'h0, any_cmd}, 32'h0);
        chk_resp("ill", 2, 32'h0, 1'b1);
        txn(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0);
        chk_resp("b2b_lb", 2, 32'hFFFFFFFE, 1'b0);

        // Crossing access wrapping past the top of the address space
        txn(1'b0, 1'b1, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0);
        chk("wrap_addr1", h_addr[1], 32'hFFFFFFFC);
        chk("wrap_addr2", h_addr[2], 32'h0);
        chk_resp("wrap", 3, 32'h0, 1'b0);

        // Reset while the crossing store is between its two writes
        txn(1'b0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h8899AABB);
        sel = 1'b0;
        req_load = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h101; req_wdata = 32'hDEADBEEF; rv_drv = 1'b1;
        @(posedge clk);
        #1 rv_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rmo_wr0_cmd", {28'h0, cmd0}, {28'h0, C_SW});
        chk("rmo_wr0_din", din0, 32'hADBEEF44);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rmo_cmd", {28'h0, cmd0}, 32'h0);
        chk("rmo_addr", addr0, 32'h0);
        chk("rmo_din", din0, 32'h0);
        chk("rmo_resp", {30'h0, rsp0, err0}, 32'h0);
        chk("rmo_ready", {31'h0, rdy0}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h0);
        chk_resp("rmo_lw100", 2, 32'hADBEEF44, 1'b0);
        txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h0);
        chk_resp("rmo_lw104", 2, 32'h8899AABB, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
